load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory port: accepts one load or store request at a time from the execute stage and drives the memory's fetch and write channels. It holds a store until the memory grants it, and it sign- or zero-extends load data. It returns a single response per request. It sits between the execute stage and the data port of the shared memory model.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; DATA_BYTE_SIZE = DATA_WIDTH/8, IDX_W = $clog2(DATA_BYTE_SIZE)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE and not in reset
- req_is_store  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, low bytes significant
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_error  out  1  request rejected, memory untouched
- mem_fetch_addr  out  ADDR_WIDTH  load address
- mem_fetched_data  in  DATA_WIDTH  little-endian bytes at mem_fetch_addr+i
- mem_fetch_done  in  1  fetched data valid this cycle
- mem_write_addr  out  ADDR_WIDTH  store address
- mem_write_data  out  DATA_WIDTH  store data
- mem_bytes_to_write  out  IDX_W+1  1, 2 or 4 while storing, else 0
- mem_write_activate  out  1  store pending
- mem_write_done  in  1  write commits at the next posedge

## Operation
- The FSM has four states: IDLE, LOAD, STORE and RESP.
- **IDLE:** on req_valid && req_ready, latch is_store, size, unsigned, addr and wdata.
  - Invalid request (size 3, or misaligned when LSU_MISALIGN_TRAP_EN is defined): go to RESP with resp_error=1 and resp_data=0.
  - Otherwise go to STORE or LOAD.
- **LOAD:** mem_fetch_addr = latched addr. When mem_fetch_done is high, register the extended data into resp_data and go to RESP. Otherwise stay in LOAD.
- **Load extension:**
  - byte: bits [7:0]; half: bits [15:0].
  - Sign-extend from the top bit of the field unless unsigned.
  - Word: passed through; req_unsigned is ignored.
- **STORE:**
  - Outputs: mem_write_activate=1, mem_write_addr and mem_write_data from the latched registers, mem_bytes_to_write = 1 << size.
  - Hold all of these unchanged until a cycle with mem_write_done=1, then go to RESP with resp_data=0.
- **RESP:** resp_valid=1; resp_data and resp_error are held stable. On resp_ready, go to IDLE. There is no accept in the RESP cycle, so at most one request is outstanding.
- Outside STORE: mem_write_activate=0 and mem_bytes_to_write=0. Outside LOAD, mem_fetch_addr holds its last value (don't-care to memory).

## Timing
- **Reset:** state IDLE. req_ready=0 while rst is high. resp_valid=0, resp_data=0, resp_error=0, mem_write_activate=0, mem_bytes_to_write=0, address/data outputs 0.
- **Reset mid-operation:** the request is abandoned. No write is issued after the rst edge, and no response is produced.
- **Load latency:** accept at edge N, LOAD during cycle N+1, resp_valid from cycle N+2 (with fetch_done tied high).
- **Store latency:** 1 + k cycles in STORE, where k is the number of cycles until mem_write_done. resp_valid appears the cycle after the granting cycle.
- **Error latency:** resp_valid the cycle after accept.
- **Response back-pressure:** resp_ready low holds RESP indefinitely.
- **Next accept:** req_ready rises the cycle after the resp handshake.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]≠0 returns resp_error=1 without touching memory.
  - A word access with addr[1:0]≠0 returns resp_error=1 without touching memory.
- Not defined: misaligned accesses proceed as normal byte-addressed accesses. Only size 3 returns an error.

## Structure
- **Package lsu_pkg:**
  - mem_size_t enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD.
  - lsu_state_t enum: IDLE, LOAD, STORE, RESP.
  - Function size_to_bytes.
- **Sub-module load_extender (combinational):** inputs raw data, size and unsigned; output extended word.

## Test plan
- **Signed byte load:** memory[0x10]=0x80; load byte signed at 0x10 -> resp_data 0xFFFFFF80, resp_error 0. The same access unsigned -> 0x00000080.
- **Half store then load:** store half 0xBEEF at 0x20 while the memory grants on alternate cycles.
  - mem_write_activate is held with bytes_to_write=2 until write_done.
  - A word load at 0x20 then returns 0x0000BEEF when the surrounding bytes are 0.
- **Misaligned word load:** word load at 0x22 with the macro defined -> resp_error 1, resp_data 0, no fetch/write. Without the macro -> data returned, error 0.
- **Reserved size:** size 3 -> resp_error 1 in both builds; mem_write_activate never rises.
- **Response back-pressure:** hold resp_ready low for 5 cycles -> resp_valid and resp_data are stable and req_ready stays 0. Raise resp_ready -> req_ready=1 the next cycle.
- **Reset mid-operation:** assert rst during STORE before write_done -> memory unchanged, all outputs at reset values, req_ready=1 the first cycle after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Access sizes, controller states and the size-to-byte-count mapping.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Number of bytes touched by an access of the given size (1, 2 or 4).
  function automatic logic [3:0] size_to_bytes(input mem_size_t size);
    return 4'd1 << size;
  endfunction

  // True when the address is not naturally aligned for the access size.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational load-data extender: selects the low byte/half/word of the
// fetched little-endian data and sign- or zero-extends it to a full word.
module load_extender
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] raw_i,
  input  mem_size_t             size_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] ext_o
);

  logic fill_byte;
  logic fill_half;

  assign fill_byte = ~unsigned_i & raw_i[7];
  assign fill_half = ~unsigned_i & raw_i[15];

  // Pick the field and replicate its sign bit (or zero) into the upper bits.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    ext_o = raw_i;
    case (size_i)
      SIZE_BYTE: ext_o = {{(DATA_WIDTH-8){fill_byte}}, raw_i[7:0]};
      SIZE_HALF: ext_o = {{(DATA_WIDTH-16){fill_half}}, raw_i[15:0]};
      default:   ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory port. Accepts one
// request at a time, drives the fetch or write channel, and returns exactly
// one response per request.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses are rejected with resp_error instead of being issued.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  localparam int DATA_BYTE_SIZE = DATA_WIDTH / 8,
  localparam int IDX_W          = $clog2(DATA_BYTE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_fetch_addr,
  input  logic [DATA_WIDTH-1:0] mem_fetched_data,
  input  logic                  mem_fetch_done,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [IDX_W:0]        mem_bytes_to_write,
  output logic                  mem_write_activate,
  input  logic                  mem_write_done
);

  localparam int BYTES_W = IDX_W + 1;

  lsu_state_t            state_q;
  mem_size_t             size_q;
  logic                  unsigned_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_error_q;
  logic [ADDR_WIDTH-1:0] fetch_addr_q;
  logic [ADDR_WIDTH-1:0] write_addr_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic [BYTES_W-1:0]    bytes_q;
  logic                  write_act_q;

  mem_size_t             req_size_d;
  logic                  req_invalid_d;
  logic [DATA_WIDTH-1:0] load_ext_d;

  assign req_size_d = mem_size_t'(req_size);

  // Classify the incoming request: reserved size always fails, misalignment only when trapping.
  always_comb begin
    req_invalid_d = (req_size_d == SIZE_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
    req_invalid_d = req_invalid_d | is_misaligned(req_size_d, req_addr[1:0]);
`else
    req_invalid_d = req_invalid_d | 1'b0;
`endif
  end

  load_extender #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extender (
    .raw_i      (mem_fetched_data),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .ext_o      (load_ext_d)
  );

  // Controller FSM with registered outputs; a synchronous reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      size_q       <= SIZE_BYTE;
      unsigned_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      fetch_addr_q <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      bytes_q      <= '0;
      write_act_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q     <= req_size_d;
            unsigned_q <= req_unsigned;
            if (req_invalid_d) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_data_q  <= '0;
              state_q      <= RESP;
            end else if (req_is_store) begin
              write_addr_q <= req_addr;
              write_data_q <= req_wdata;
              bytes_q      <= BYTES_W'(size_to_bytes(req_size_d));
              write_act_q  <= 1'b1;
              state_q      <= STORE;
            end else begin
              fetch_addr_q <= req_addr;
              state_q      <= LOAD;
            end
          end
        end
        LOAD: begin
          if (mem_fetch_done) begin
            resp_data_q  <= load_ext_d;
            resp_error_q <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        STORE: begin
          // Write channel stays frozen until the memory grants it.
          if (mem_write_done) begin
            write_act_q  <= 1'b0;
            bytes_q      <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready          = (state_q == IDLE) && !rst;
  assign resp_valid         = resp_valid_q;
  assign resp_data          = resp_data_q;
  assign resp_error         = resp_error_q;
  assign mem_fetch_addr     = fetch_addr_q;
  assign mem_write_addr     = write_addr_q;
  assign mem_write_data     = write_data_q;
  assign mem_bytes_to_write = bytes_q;
  assign mem_write_activate = write_act_q;

endmodule
